fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the Abejaruco core. It replaces the fixed boot-address PC register in the top level.
- Owns the PC and issues one outstanding read at a time to the instruction cache (access/hit/miss protocol).
- Buffers returned instructions in a small FIFO toward decode, using a valid/ready handshake.
- Supports redirect (branch/exception) with a kill of in-flight responses.

Parameters:
- XLEN, 32, width of PC, address and instruction word
- BOOT_ADDR, 32'h1000, PC value loaded on reset
- QUEUE_DEPTH, 2, fetch FIFO entries; power of two, ≥2
- INSTR_BYTES, 4, PC increment per fetched instruction

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- icache_access  out  1  read request; held until hit
- icache_address  out  XLEN  fetch address; stable while icache_access=1
- icache_op  out  1  constant 0 (read)
- icache_data_out  in  XLEN  instruction word, valid when icache_hit=1
- icache_hit  in  1  response valid this cycle
- icache_miss  in  1  miss in progress (informational; increments miss counter)
- redirect_valid  in  1  one-cycle request to change PC
- redirect_pc  in  XLEN  new PC
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  XLEN  head instruction
- instr_pc  out  XLEN  head PC
- misaligned  out  1  sticky: redirect_pc not INSTR_BYTES-aligned
- miss_count  out  16  saturating icache miss-cycle counter

Behaviour:
- Reset (asynchronous, active-low; one clock; reset is asynchronous and active-low):
  - pc=BOOT_ADDR, state=IDLE, FIFO empty.
  - icache_access=0, instr_valid=0, misaligned=0, miss_count=0, kill=0.
  - Reset asserted mid-request drops the request immediately. No response is consumed after reset release.
- States: IDLE, REQ, DRAIN.
  - IDLE: the first cycle after reset release, or when the FIFO has no free slot. Go to REQ when free slots ≥1, counting a same-cycle pop as freeing a slot.
  - REQ: icache_access=1, icache_address=pc. On a cycle with icache_hit=1 and kill=0:
    - push {pc, icache_data_out};
    - pc += INSTR_BYTES (wraps modulo 2^XLEN);
    - stay in REQ if a slot remains after the push, else go to IDLE.
    - Back-to-back hits give one instruction per cycle.
  - DRAIN: an outstanding request was killed by redirect. Keep access and address unchanged until hit, discard that data (no push), then go to REQ with pc=redirect target.
- Redirect:
  - Effective in the cycle it is sampled: FIFO flushed (instr_valid=0 next cycle), pc=redirect_pc.
  - If in REQ and hit is not in the same cycle, go to DRAIN with the target held in pending_pc.
  - If hit coincides with redirect, the hit data is discarded and the next state is REQ at redirect_pc.
  - A redirect during DRAIN overwrites pending_pc.
  - redirect_pc & (INSTR_BYTES-1) ≠ 0 sets misaligned (sticky until reset). The PC is still loaded.
- FIFO:
  - Push and pop in the same cycle on a full FIFO is legal only when the pop frees a slot; count is unchanged.
  - Pop occurs when instr_valid && instr_ready.
  - Pointers wrap modulo QUEUE_DEPTH. The extra wrap bit distinguishes full from empty.
- Outputs instr and instr_pc are registered from the FIFO head with no combinational path from icache_hit.
- Latency:
  - Hit sampled at edge N gives instr_valid at N (visible after edge N).
  - Reset release to first icache_access is 1 cycle.
- miss_count increments each cycle icache_miss=1 and saturates at 16'hFFFF.
- icache_hit while icache_access=0 is ignored.

Decomposition:
- Shared package/header fetch_defs.vh holds:
  - state encodings FETCH_IDLE/FETCH_REQ/FETCH_DRAIN;
  - BOOT_ADDR default;
  - ICACHE_OP_READ=1'b0.
- One sub-module: fetch_queue (parametrised width/depth synchronous FIFO with flush, push, pop, full, empty). The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset release with a cache that hits every cycle and instr_ready=1 → icache_address 0x1000, 0x1004, 0x1008…; instr_pc follows one cycle later; one instruction per cycle.
- instr_ready=0, QUEUE_DEPTH=2 → exactly 2 pushes (0x1000, 0x1004), then icache_access=0. Raising ready resumes at 0x1008 with no duplicates or skips.
- Cache asserts miss for 5 cycles, then hit → address held at 0x1000 throughout; miss_count=5; a single push.
- redirect_valid to 0x2000 while a request to 0x1008 is pending (hit 3 cycles later) → address held at 0x1008 until hit; data discarded; next request at 0x2000; FIFO flushed the cycle after redirect.
- Redirect coincident with a hit at 0x1004, target 0x3000 → no push of the 0x1004 data; next icache_address 0x3000.
- redirect_pc=0x2002 → misaligned=1 and it stays set. Reset asserted mid-DRAIN → all outputs return to reset values asynchronously; the first request after release is at 0x1000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding,
// default boot address and the icache operation code.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BootAddrDefault = 32'h0000_1000;
  localparam logic        IcacheOpRead    = 1'b0;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO with flush; pointers carry an extra wrap bit so full and
// empty are distinguishable. Depth must be a power of two, at least 2.
module fetch_unit_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AddrW-1:0]];

  // A push into a full queue is accepted only if the same-cycle pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AddrW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AddrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one icache read outstanding,
// buffers returned instructions toward decode and handles redirects.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR   = XLEN'(BootAddrDefault),
  parameter int unsigned     QUEUE_DEPTH = 2,
  parameter int unsigned     INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            icache_access,
  output logic [XLEN-1:0] icache_address,
  output logic            icache_op,
  input  logic [XLEN-1:0] icache_data_out,
  input  logic            icache_hit,
  input  logic            icache_miss,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned,
  output logic [15:0]     miss_count
);

  localparam int unsigned CountW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pending_q, pending_d;
  logic              misaligned_q;
  logic [15:0]       miss_count_q;

  logic              push, pop;
  logic              q_full, q_empty;
  logic [CountW-1:0] q_count;
  logic [2*XLEN-1:0] q_head;
  logic              has_slot, slot_after_push;

  assign icache_access  = (state_q != StIdle);
  assign icache_address = pc_q;
  assign icache_op      = IcacheOpRead;
  assign instr_valid    = !q_empty;
  assign instr_pc       = q_head[2*XLEN-1:XLEN];
  assign instr          = q_head[XLEN-1:0];
  assign misaligned     = misaligned_q;
  assign miss_count     = miss_count_q;

  assign pop             = instr_valid && instr_ready;
  assign has_slot        = !q_full || pop;
  assign slot_after_push = (q_count != CountW'(QUEUE_DEPTH - 1)) || pop;

  // In DRAIN pc_q still holds the killed request's address so the icache sees
  // it unchanged; the redirect target waits in pending_q until the hit.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (has_slot) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect_valid) begin
          if (icache_hit) begin
            pc_d    = redirect_pc;
            state_d = StReq;
          end else begin
            pending_d = redirect_pc;
            state_d   = StDrain;
          end
        end else if (icache_hit) begin
          push    = 1'b1;
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
          state_d = slot_after_push ? StReq : StIdle;
        end
      end
      StDrain: begin
        if (redirect_valid) pending_d = redirect_pc;
        if (icache_hit) begin
          pc_d    = redirect_valid ? redirect_pc : pending_q;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= BOOT_ADDR;
      pending_q    <= BOOT_ADDR;
      misaligned_q <= 1'b0;
      miss_count_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      if (redirect_valid && ((redirect_pc & XLEN'(INSTR_BYTES - 1)) != '0)) begin
        misaligned_q <= 1'b1;
      end
      if (icache_miss && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'h0001;
      end
    end
  end

  fetch_unit_queue #(
    .Width (2 * XLEN),
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc_q, icache_data_out}),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule
